// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with an optional skid entry (enable with EX_MEM_SKID_EN).
// Without the macro it is a single-entry register whose in_ready looks through out_ready.
module ex_mem_skid #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEMOP_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_rd_data,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_rd_enable,
  input  logic [MEMOP_W-1:0]    in_mem_op,
  input  logic [DATA_W-1:0]     in_mem_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_rd_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_rd_enable,
  output logic [MEMOP_W-1:0]    out_mem_op,
  output logic [DATA_W-1:0]     out_mem_addr,
  output logic [1:0]            count
);

  typedef struct packed {
    logic [DATA_W-1:0]     rd_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_enable;
    logic [MEMOP_W-1:0]    mem_op;
    logic [DATA_W-1:0]     mem_addr;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t in_ent;
  logic   in_xfer, out_xfer;

`ifdef EX_MEM_SKID_EN
  entry_t skid_q, skid_d;
  assign in_ready = rdy & (state_q != S_TWO);
`else
  assign in_ready = rdy & ((state_q == S_EMPTY) | out_ready);
`endif

  assign out_valid = rdy & (state_q != S_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign count     = state_q;

  assign in_ent = '{rd_data:   in_rd_data,
                    rd_addr:   in_rd_addr,
                    rd_enable: in_rd_enable,
                    mem_op:    in_mem_op,
                    mem_addr:  in_mem_addr};

  // rdy=0 needs no explicit hold: both transfer strobes already include rdy.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef EX_MEM_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d = S_ONE;
            main_d  = in_ent;
          end
        end
        S_ONE: begin
`ifdef EX_MEM_SKID_EN
          if (in_xfer && out_xfer) begin
            main_d = in_ent;
          end else if (in_xfer) begin
            state_d = S_TWO;
            skid_d  = in_ent;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
`else
          // in_xfer implies out_xfer here, since in_ready follows out_ready.
          if (in_xfer) begin
            main_d = in_ent;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
`endif
        end
`ifdef EX_MEM_SKID_EN
        S_TWO: begin
          if (out_xfer) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
`ifdef EX_MEM_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef EX_MEM_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  assign out_rd_data   = main_q.rd_data;
  assign out_rd_addr   = main_q.rd_addr;
  assign out_rd_enable = main_q.rd_enable & (main_q.rd_addr != '0);
  assign out_mem_op    = main_q.mem_op;
  assign out_mem_addr  = main_q.mem_addr;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid; a negedge monitor models occupancy and ordering.
module tb_ex_mem_skid;
  logic        clk, rst, rdy, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_rd_data, in_mem_addr;
  logic [4:0]  in_rd_addr;
  logic        in_rd_enable;
  logic [3:0]  in_mem_op;
  logic        out_valid, out_ready;
  logic [31:0] out_rd_data, out_mem_addr;
  logic [4:0]  out_rd_addr;
  logic        out_rd_enable;
  logic [3:0]  out_mem_op;
  logic [1:0]  count;

  ex_mem_skid dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_data(in_rd_data), .in_rd_addr(in_rd_addr), .in_rd_enable(in_rd_enable),
    .in_mem_op(in_mem_op), .in_mem_addr(in_mem_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_data(out_rd_data), .out_rd_addr(out_rd_addr), .out_rd_enable(out_rd_enable),
    .out_mem_op(out_mem_op), .out_mem_addr(out_mem_addr),
    .count(count)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic        en;
    logic [3:0]  op;
    logic [31:0] ma;
  } ent_t;

  ent_t sb[$];
  int   n_chk = 0, n_err = 0;
  int   mcnt  = 0;
  bit   armed = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] d, input logic [4:0] a,
                     input logic en, input logic [3:0] op, input logic [31:0] ma);
    in_valid = v; in_rd_data = d; in_rd_addr = a;
    in_rd_enable = en; in_mem_op = op; in_mem_addr = ma;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, out_rd_data, 0);
    chk({tag, "_addr"}, out_rd_addr, 0);
    chk({tag, "_en"},   out_rd_enable, 0);
    chk({tag, "_op"},   out_mem_op, 0);
    chk({tag, "_maddr"}, out_mem_addr, 0);
  endtask

  // Reference model: occupancy, handshake outputs and in-order payload.
  always @(negedge clk) begin
    logic e_in_rdy, e_out_vld, i, o;
    ent_t e;
    if (rst) begin
      mcnt = 0;
      sb.delete();
      armed = 1;
    end else if (armed) begin
`ifdef EX_MEM_SKID_EN
      e_in_rdy = rdy && (mcnt != 2);
`else
      e_in_rdy = rdy && (mcnt == 0 || out_ready);
`endif
      e_out_vld = rdy && (mcnt != 0);
      chk("count", count, mcnt);
      chk("in_ready", in_ready, e_in_rdy);
      chk("out_valid", out_valid, e_out_vld);
      if (flush) begin
        mcnt = 0;
        sb.delete();
      end else begin
        o = e_out_vld && out_ready;
        i = in_valid && e_in_rdy;
        if (o) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("out_rd_data", out_rd_data, e.d);
            chk("out_rd_addr", out_rd_addr, e.a);
            chk("out_rd_enable", out_rd_enable, e.en && (e.a != 0));
            chk("out_mem_op", out_mem_op, e.op);
            chk("out_mem_addr", out_mem_addr, e.ma);
          end
        end
        if (i) begin
          e.d = in_rd_data; e.a = in_rd_addr; e.en = in_rd_enable;
          e.op = in_mem_op; e.ma = in_mem_addr;
          sb.push_back(e);
        end
        mcnt = mcnt + int'(i) - int'(o);
      end
    end
  end

  initial begin
    rst = 1; rdy = 1; flush = 0; out_ready = 0;
    drv(0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 0;
    step();
    chk_zero("rst_idle");
    chk("rst_count", count, 0);

`ifdef EX_MEM_SKID_EN
    // Fill both entries, then drain A then B.
    drv(1, 32'h11, 5'd3, 1, 4'h1, 32'h1000); step();
    drv(1, 32'h22, 5'd4, 1, 4'h2, 32'h2000); step();
    drv(0, 0, 0, 0, 0, 0);
    chk("skid_full_count", count, 2);
    chk("skid_full_in_ready", in_ready, 0);
    out_ready = 1;
    step();
    chk("skid_drain1", count, 1);
    chk("skid_head_b", out_rd_data, 32'h22);
    step();
    chk("skid_drain0", count, 0);
    out_ready = 0;
`else
    // Single entry: in_ready follows out_ready combinationally.
    drv(1, 32'h11, 5'd3, 1, 4'h1, 32'h1000); step();
    drv(1, 32'h22, 5'd4, 1, 4'h2, 32'h2000);
    chk("one_in_ready_blocked", in_ready, 0);
    out_ready = 1;
    #1;
    chk("one_in_ready_comb", in_ready, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("one_replace_count", count, 1);
    chk("one_replace_data", out_rd_data, 32'h22);
    step();
    out_ready = 0;
`endif

    // Streaming 1..8.
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      drv(1, k, 5'(k), 1, 4'(k), 32'h100 + k);
      step();
      chk("stream_count", count, 1);
    end
    drv(0, 0, 0, 0, 0, 0);
    step();
    chk("stream_empty", count, 0);
    chk("hold_data", out_rd_data, 8);

    // x0 write suppression and rdy freeze.
    out_ready = 0;
    drv(1, 32'h5A, 5'd0, 1, 4'h3, 32'h300); step();
    drv(0, 0, 0, 0, 0, 0);
    chk("x0_en", out_rd_enable, 0);
    rdy = 0; out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("freeze_count", count, 1);
      chk("freeze_data", out_rd_data, 32'h5A);
      chk("freeze_maddr", out_mem_addr, 32'h300);
    end
    rdy = 1;
    step();
    chk("unfreeze_drain", count, 0);

    // Flush while occupied, with an entry offered the same cycle.
    out_ready = 0;
    drv(1, 32'hA1, 5'd1, 1, 4'h1, 32'h10); step();
`ifdef EX_MEM_SKID_EN
    drv(1, 32'hA2, 5'd2, 1, 4'h1, 32'h20); step();
    chk("flush_pre_count", count, 2);
`endif
    drv(1, 32'hBB, 5'd5, 1, 4'h1, 32'h30);
    flush = 1;
    step();
    flush = 0;
    drv(0, 0, 0, 0, 0, 0);
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1;
    step(); step();

    // Reset mid-operation.
    out_ready = 0;
    drv(1, 32'hC1, 5'd6, 1, 4'h7, 32'h40); step();
    drv(1, 32'hC2, 5'd7, 1, 4'h7, 32'h50); step();
    drv(0, 0, 0, 0, 0, 0);
    rst = 1; flush = 1; rdy = 0;
    step();
    rst = 0; flush = 0; rdy = 1;
    chk_zero("rst_mid");
    chk("rst_mid_count", count, 0);
    step();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rdy       = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drv($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 3)),
          $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom);
      step();
    end
    flush = 0; rdy = 1; out_ready = 1;
    drv(0, 0, 0, 0, 0, 0);
    step(); step(); step();
    chk("final_empty", count, 0);
    chk("sb_left", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
